// File: rtl/sig_pkg.sv
// Shared lamp codes, phase encodings and small helpers for the highway/country
// signal controller.
package sig_pkg;

    typedef enum logic [1:0] {
        LAMP_RED    = 2'd0,
        LAMP_YELLOW = 2'd1,
        LAMP_GREEN  = 2'd2
    } lamp_t;

    typedef enum logic [2:0] {
        S0 = 3'd0,  // highway green, country red
        S1 = 3'd1,  // highway yellow
        S2 = 3'd2,  // all red before country green
        S3 = 3'd3,  // country green
        S4 = 3'd4,  // country yellow
        S5 = 3'd5   // all red before highway green
    } state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic lamp_t hwy_lamp(input state_t s);
        case (s)
            S0:      return LAMP_GREEN;
            S1:      return LAMP_YELLOW;
            default: return LAMP_RED;
        endcase
    endfunction

    function automatic lamp_t cntry_lamp(input state_t s);
        case (s)
            S3:      return LAMP_GREEN;
            S4:      return LAMP_YELLOW;
            default: return LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/sig_tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_PER_TICK clocks, never
// realigned by phase changes.
module sig_tick_gen #(
    parameter int CLK_PER_TICK = 100
) (
    input  logic clock,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLK_PER_TICK);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_TICK - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg + 1'b1;
        if (count_reg == LAST) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign tick = (count_reg == LAST);

endmodule

// File: rtl/sig_phase_sequencer.sv
// Timed highway/country traffic-light controller: sensor synchronizer, phase
// timer, six-phase FSM and registered lamp outputs.
module sig_phase_sequencer
    import sig_pkg::*;
#(
    parameter int CLK_PER_TICK    = 100,
    parameter int YELLOW_TICKS    = 4,
    parameter int Y2R_TICKS       = 3,
    parameter int R2G_TICKS       = 2,
    parameter int HWY_MIN_GREEN   = 10,
    parameter int CNTRY_MAX_GREEN = 20
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       X,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [2:0] state
);

    localparam int TMAX = max_of(max_of(max_of(YELLOW_TICKS, Y2R_TICKS),
                                        max_of(R2G_TICKS, HWY_MIN_GREEN)),
                                 CNTRY_MAX_GREEN);
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TIMER_SAT = TW'(TMAX);

    logic tick;

    sig_tick_gen #(
        .CLK_PER_TICK(CLK_PER_TICK)
    ) u_tick_gen (
        .clock(clock),
        .clear(clear),
        .tick (tick)
    );

    logic [1:0]    sync_reg;
    logic          x_s;
    state_t        state_reg;
    state_t        state_next;
    logic [TW-1:0] timer_reg;
    logic [TW-1:0] timer_next;
    logic [1:0]    hwy_reg;
    logic [1:0]    cntry_reg;

    logic yel_done;
    logic y2r_done;
    logic r2g_done;
    logic max_done;
    logic min_green_met;

    assign x_s = sync_reg[1];

    // "N ticks elapsed" fires on the tick that would bring the count to N.
    assign yel_done      = tick && (timer_reg == TW'(YELLOW_TICKS - 1));
    assign y2r_done      = tick && (timer_reg == TW'(Y2R_TICKS - 1));
    assign r2g_done      = tick && (timer_reg == TW'(R2G_TICKS - 1));
    assign max_done      = tick && (timer_reg == TW'(CNTRY_MAX_GREEN - 1));
    assign min_green_met = (timer_reg >= TW'(HWY_MIN_GREEN));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S0: if (x_s && min_green_met) state_next = S1;
            S1: if (yel_done)             state_next = S2;
            S2: if (y2r_done)             state_next = S3;
            S3: if (!x_s || max_done)     state_next = S4;
            S4: if (yel_done)             state_next = S5;
            S5: if (r2g_done)             state_next = S0;
            default:                      state_next = S0;
        endcase
    end

    always_comb begin
        timer_next = timer_reg;
        if (state_next != state_reg) begin
            timer_next = '0;
        end else if (tick && (timer_reg != TIMER_SAT)) begin
            timer_next = timer_reg + 1'b1;
        end
    end

    // Lamps are loaded from the next-state decode so they switch with state.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            sync_reg  <= 2'b00;
            state_reg <= S0;
            timer_reg <= '0;
            hwy_reg   <= LAMP_GREEN;
            cntry_reg <= LAMP_RED;
        end else begin
            sync_reg  <= {sync_reg[0], X};
            state_reg <= state_next;
            timer_reg <= timer_next;
            hwy_reg   <= hwy_lamp(state_next);
            cntry_reg <= cntry_lamp(state_next);
        end
    end

    assign hwy   = hwy_reg;
    assign cntry = cntry_reg;
    assign state = state_reg;

endmodule
